hazard_scoreboard: RTL and testbench

//  Issue controller for the ID->EX boundary of the EX/MEM/SAD/SADD/SSAD/WB pipeline.

---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/hazard_scoreboard_ready_counter.sv | 35 +++
 rtl/hazard_scoreboard.sv | 87 ++++++++
 tb/tb_hazard_scoreboard.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared latency-class codes and default producer latencies
// used by the issue scoreboard, pipeline and forwarding logic.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    LAT_CLASS_ALU  = 2'd0,
    LAT_CLASS_LOAD = 2'd1,
    LAT_CLASS_SAD  = 2'd2,
    LAT_CLASS_RSV  = 2'd3
  } lat_class_e;

  localparam int LAT_ALU_DEF  = 1;
  localparam int LAT_LOAD_DEF = 2;
  localparam int LAT_SAD_DEF  = 4;
  localparam int CW_DEF       = 3;

endpackage

// File: rtl/hazard_scoreboard_ready_counter.sv
// Per-register ready counter: decrements toward zero every cycle and
// on load keeps the larger of the decremented value and the new latency.
module reg_ready_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          nonzero
);

  logic [CW-1:0] dec;
  logic [CW-1:0] nxt;

  always_comb begin
    dec = (cnt != '0) ? cnt - 1'b1 : '0;
    nxt = dec;
    if (load && (load_val > dec)) begin
      nxt = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

  assign nonzero = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID->EX issue scoreboard: stalls ID until sources are forwardable.
// Optional HAZARD_STALL_STATS_EN adds a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_ALU  = LAT_ALU_DEF,
  parameter int LAT_LOAD = LAT_LOAD_DEF,
  parameter int LAT_SAD  = LAT_SAD_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_writes,
  input  logic [4:0]  id_wr_reg,
  input  logic [1:0]  id_lat_class,
  input  logic        flush,
  output logic        stall,
  output logic        issue_fire,
  output logic [31:0] pending_mask,
  output logic [31:0] stall_cycles
);

  localparam logic [CW-1:0] LV_ALU  = CW'(LAT_ALU - 1);
  localparam logic [CW-1:0] LV_LOAD = CW'(LAT_LOAD - 1);
  localparam logic [CW-1:0] LV_SAD  = CW'(LAT_SAD - 1);

  logic [CW-1:0] cnt [32];
  logic [31:0]   nz;
  logic [CW-1:0] lat_val;
  logic          hazard;
  logic          wr_en;

  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  always_comb begin
    lat_val = LV_SAD;
    case (id_lat_class)
      LAT_CLASS_ALU:  lat_val = LV_ALU;
      LAT_CLASS_LOAD: lat_val = LV_LOAD;
      default:        lat_val = LV_SAD;
    endcase
  end

  assign hazard = (id_use_rs & nz[id_rs])
                | (id_use_rt & nz[id_rt]);
  assign stall      = id_valid & ~flush & hazard;
  assign issue_fire = id_valid & ~flush & ~hazard;
  assign wr_en = issue_fire & id_writes
               & (id_wr_reg != 5'd0);

  for (genvar r = 1; r < 32; r++) begin : g_cnt
    reg_ready_counter #(.CW(CW)) u_cnt (
      .clk      (Clk),
      .reset    (Reset),
      .load     (wr_en && (id_wr_reg == 5'(r))),
      .load_val (lat_val),
      .cnt      (cnt[r]),
      .nonzero  (nz[r])
    );
  end

  // Flags come straight from the counter flops, so they move on the same edge.
  assign pending_mask = nz;

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stat_q <= '0;
    end else if (stall && (stat_q != 32'hFFFF_FFFF)) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stall_cycles = stat_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: latency classes, WAW max,
// r0, flush, reset mid-stall and the optional stall statistics.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_wr_reg;
  logic        id_use_rs, id_use_rt, id_writes;
  logic [1:0]  id_lat_class;
  logic        flush;
  logic        stall, issue_fire;
  logic [31:0] pending_mask, stall_cycles;

  int checks = 0;
  int failures = 0;

`ifdef HAZARD_STALL_STATS_EN
  localparam logic [31:0] EXP_STATS = 32'd6;
`else
  localparam logic [31:0] EXP_STATS = 32'd0;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .Clk          (clk),
    .Reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_writes    (id_writes),
    .id_wr_reg    (id_wr_reg),
    .id_lat_class (id_lat_class),
    .flush        (flush),
    .stall        (stall),
    .issue_fire   (issue_fire),
    .pending_mask (pending_mask),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Drive on the falling edge; settle before checking mid-cycle.
  task automatic drive(input logic v,
                       input logic [4:0] rs,
                       input logic urs,
                       input logic wr,
                       input logic [4:0] wreg,
                       input logic [1:0] cls,
                       input logic fl);
    @(negedge clk);
    id_valid = v;
    id_rs = rs;
    id_rt = 5'd0;
    id_use_rs = urs;
    id_use_rt = 1'b0;
    id_writes = wr;
    id_wr_reg = wreg;
    id_lat_class = cls;
    flush = fl;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 1'b0;
    id_rs = '0; id_rt = '0; id_wr_reg = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_writes = 1'b0; id_lat_class = 2'd0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fire", {31'd0, issue_fire}, 32'd0);
    chk("rst_pend", pending_mask, 32'd0);
    chk("rst_stats", stall_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ALU -> ALU back-to-back
    drive(1, 5'd1, 1, 1, 5'd5, 2'd0, 0);
    chk("alu1_fire", {31'd0, issue_fire}, 32'd1);
    drive(1, 5'd5, 1, 1, 5'd6, 2'd0, 0);
    chk("alu2_fire", {31'd0, issue_fire}, 32'd1);
    chk("alu2_stall", {31'd0, stall}, 32'd0);
    chk("alu2_pend", pending_mask, 32'd0);

    // LOAD -> use: one stall
    drive(1, 5'd0, 0, 1, 5'd8, 2'd1, 0);
    chk("ld_fire", {31'd0, issue_fire}, 32'd1);
    drive(1, 5'd8, 1, 0, 5'd0, 2'd0, 0);
    chk("ld_stall", {31'd0, stall}, 32'd1);
    chk("ld_pend", pending_mask, 32'h0000_0100);
    drive(1, 5'd8, 1, 0, 5'd0, 2'd0, 0);
    chk("ld_use_fire", {31'd0, issue_fire}, 32'd1);
    chk("ld_pend0", pending_mask, 32'd0);

    // SAD -> use: three stalls
    drive(1, 5'd0, 0, 1, 5'd10, 2'd2, 0);
    chk("sad_fire", {31'd0, issue_fire}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd10, 1, 0, 5'd0, 2'd0, 0);
      chk("sad_stall", {31'd0, stall}, 32'd1);
    end
    drive(1, 5'd10, 1, 0, 5'd0, 2'd0, 0);
    chk("sad_use_fire", {31'd0, issue_fire}, 32'd1);
    chk("sad_pend0", pending_mask, 32'd0);

    // WAW: SAD r3 then ALU r3, reader waits on SAD
    drive(1, 5'd0, 0, 1, 5'd3, 2'd2, 0);
    drive(1, 5'd0, 0, 1, 5'd3, 2'd0, 0);
    chk("waw_alu_fire", {31'd0, issue_fire}, 32'd1);
    drive(1, 5'd3, 1, 0, 5'd0, 2'd0, 0);
    chk("waw_stall1", {31'd0, stall}, 32'd1);
    chk("waw_pend", pending_mask, 32'h0000_0008);
    drive(1, 5'd3, 1, 0, 5'd0, 2'd0, 0);
    chk("waw_stall2", {31'd0, stall}, 32'd1);
    drive(1, 5'd3, 1, 0, 5'd0, 2'd0, 0);
    chk("waw_fire", {31'd0, issue_fire}, 32'd1);

    // r0 is never pending
    drive(1, 5'd0, 0, 1, 5'd0, 2'd1, 0);
    drive(1, 5'd0, 1, 0, 5'd0, 2'd0, 0);
    chk("r0_fire", {31'd0, issue_fire}, 32'd1);
    chk("r0_pend", pending_mask, 32'd0);
    chk("stats", stall_cycles, EXP_STATS);

    // flush on a LOAD hazard
    drive(1, 5'd0, 0, 1, 5'd8, 2'd1, 0);
    drive(1, 5'd8, 1, 0, 5'd0, 2'd0, 1);
    chk("fl_stall", {31'd0, stall}, 32'd0);
    chk("fl_fire", {31'd0, issue_fire}, 32'd0);
    drive(1, 5'd8, 1, 0, 5'd0, 2'd0, 0);
    chk("fl_dec_fire", {31'd0, issue_fire}, 32'd1);
    chk("fl_stats", stall_cycles, EXP_STATS);

    // reset while waiting on a SAD result
    drive(1, 5'd0, 0, 1, 5'd10, 2'd2, 0);
    drive(1, 5'd10, 1, 0, 5'd0, 2'd0, 0);
    chk("rs_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    drive(1, 5'd10, 1, 0, 5'd0, 2'd0, 0);
    reset = 1'b0;
    #1;
    chk("rs_nostall", {31'd0, stall}, 32'd0);
    chk("rs_fire", {31'd0, issue_fire}, 32'd1);
    chk("rs_pend", pending_mask, 32'd0);
    chk("rs_stats", stall_cycles, 32'd0);

    drive(0, 5'd0, 0, 0, 5'd0, 2'd0, 0);
    chk("idle_fire", {31'd0, issue_fire}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
